// File: rtl/add32_rr_sched_pkg.sv
// Shared constants and helpers for the add32_rr_sched block.
//   ADD_W            datapath width of one add (one requester operand slice)
//   DEF_NREQ/DEF_IDW default requester count and response-id width
//   NGRP, grp_w/grp_lo  group layout of the square-root carry-select adder
//   slice_lo         bit offset of requester i's operand in the packed buses
package add32_rr_sched_pkg;

    localparam int ADD_W    = 32;
    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;

    // Group widths grow roughly with the square root of position so that the
    // ripple inside each group finishes about when its select carry arrives.
    // 2+2+3+4+5+6+10 = 32.
    localparam int NGRP = 7;

    function automatic int grp_w(input int g);
        case (g)
            0:       return 2;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 5;
            5:       return 6;
            default: return 10;
        endcase
    endfunction

    function automatic int grp_lo(input int g);
        int lo;
        lo = 0;
        for (int i = 0; i < g; i++) begin
            lo = lo + grp_w(i);
        end
        return lo;
    endfunction

    function automatic int slice_lo(input int i);
        return i * ADD_W;
    endfunction

endpackage

// File: rtl/add32_rr_sched_rr_pick.sv
// Round-robin picker (module rr_pick): first set request at or above ptr,
// wrapping modulo NREQ.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IDW   highest-priority index this cycle (0..NREQ-1)
//   grant  out NREQ  one-hot grant, zero when no request
//   id     out IDW   encoded index of the granted requester
//   any    out 1     some request was granted
module rr_pick
    import add32_rr_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    always_comb begin
        logic [IDW-1:0] idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scb_cla32.sv
// 32-bit square-root carry-select adder using binary-to-excess-1 conversion.
// The lowest group ripples with the real carry-in; every higher group computes
// its cin=0 sum once and derives the cin=1 sum with an incrementer, then the
// incoming group carry selects between the two.
// Ports:
//   a, b  in  32  operands
//   cin   in  1   carry-in
//   s     out 32  sum (mod 2^32)
//   cout  out 1   carry-out
module scb_cla32
    import add32_rr_sched_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] s,
    output logic             cout
);

    logic [NGRP:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            localparam int LO = grp_lo(gi);
            localparam int W  = grp_w(gi);

            if (gi == 0) begin : g_rca
                logic [W:0] sum;
                assign sum        = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, c[0]};
                assign s[LO +: W] = sum[W-1:0];
                assign c[gi+1]    = sum[W];
            end else begin : g_bec
                logic [W:0] sum0;
                logic [W:0] sum1;
                assign sum0       = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
                // Excess-1 of the carry-free sum; cannot overflow W+1 bits.
                assign sum1       = sum0 + {{W{1'b0}}, 1'b1};
                assign s[LO +: W] = c[gi] ? sum1[W-1:0] : sum0[W-1:0];
                assign c[gi+1]    = c[gi] ? sum1[W]     : sum0[W];
            end
        end
    endgenerate

    assign cout = c[NGRP];

endmodule

// File: rtl/add32_rr_sched.sv
// Time-shares one scb_cla32 adder among NREQ requesters with a round-robin
// grant, one add per cycle. Each requester owns a carry register so it can
// chain 32-bit adds into wider sums.
// Configuration macro: ADD32_SCHED_PIPE_EN adds a second output register
// stage (latency 2); without it the result is registered once (latency 1).
// Ports:
//   clk         in  1        clock
//   rst         in  1        synchronous active-high reset
//   req_valid   in  NREQ     request pending per requester
//   req_chain   in  NREQ     use stored carry as cin
//   req_cin     in  NREQ     explicit carry-in
//   req_x/req_y in  32*NREQ  operands, slice [32i+31:32i]
//   req_ready   out NREQ     one-hot grant
//   resp_valid  out 1        one-cycle pulse per accepted request
//   resp_id     out IDW      owner of resp_s/resp_cout
//   resp_s      out 32       sum
//   resp_cout   out 1        carry-out
module add32_rr_sched
    import add32_rr_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_chain,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [ADD_W*NREQ-1:0] req_x,
    input  logic [ADD_W*NREQ-1:0] req_y,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [ADD_W-1:0]      resp_s,
    output logic                  resp_cout
);

    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  carry_q_reg;

    logic [NREQ-1:0]  req_eff;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;

    logic [ADD_W-1:0] x_arr [NREQ];
    logic [ADD_W-1:0] y_arr [NREQ];
    logic [ADD_W-1:0] add_x;
    logic [ADD_W-1:0] add_y;
    logic             add_cin;
    logic [ADD_W-1:0] add_s;
    logic             add_cout;

    logic             s1_valid_reg;
    logic [IDW-1:0]   s1_id_reg;
    logic [ADD_W-1:0] s1_s_reg;
    logic             s1_cout_reg;

    // No grants are issued while reset is held.
    assign req_eff = rst ? '0 : req_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_eff),
        .ptr   (ptr_reg),
        .grant (grant),
        .id    (grant_id),
        .any   (grant_any)
    );

    assign req_ready = grant;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign x_arr[gi] = req_x[slice_lo(gi) +: ADD_W];
            assign y_arr[gi] = req_y[slice_lo(gi) +: ADD_W];
        end
    endgenerate

    assign add_x   = x_arr[grant_id];
    assign add_y   = y_arr[grant_id];
    assign add_cin = req_chain[grant_id] ? carry_q_reg[grant_id] : req_cin[grant_id];

    scb_cla32 u_add (
        .a    (add_x),
        .b    (add_y),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            carry_q_reg  <= '0;
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            s1_s_reg     <= '0;
            s1_cout_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= grant_any;
            if (grant_any) begin
                ptr_reg               <= ptr_next;
                carry_q_reg[grant_id] <= add_cout;
                s1_id_reg             <= grant_id;
                s1_s_reg              <= add_s;
                s1_cout_reg           <= add_cout;
            end
        end
    end

    logic             out_valid;
    logic [IDW-1:0]   out_id;
    logic [ADD_W-1:0] out_s;
    logic             out_cout;

`ifdef ADD32_SCHED_PIPE_EN
    logic             s2_valid_reg;
    logic [IDW-1:0]   s2_id_reg;
    logic [ADD_W-1:0] s2_s_reg;
    logic             s2_cout_reg;

    // Data only advances with a valid result so idle outputs hold the last sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_id_reg    <= '0;
            s2_s_reg     <= '0;
            s2_cout_reg  <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_id_reg   <= s1_id_reg;
                s2_s_reg    <= s1_s_reg;
                s2_cout_reg <= s1_cout_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_id    = s2_id_reg;
    assign out_s     = s2_s_reg;
    assign out_cout  = s2_cout_reg;
`else
    assign out_valid = s1_valid_reg;
    assign out_id    = s1_id_reg;
    assign out_s     = s1_s_reg;
    assign out_cout  = s1_cout_reg;
`endif

    // A result already in the output register when reset arrives belongs to a
    // discarded transaction; masking here keeps it from being seen at all.
    assign resp_valid = out_valid & ~rst;
    assign resp_id    = out_id;
    assign resp_s     = out_s;
    assign resp_cout  = out_cout;

endmodule
